gcd_controller: RTL and testbench

Sequencing FSM for the subtract-and-compare GCD datapath.
- Accepts two operands over a valid/ready handshake and steers the shared data bus into the A then B registers.
- Repeatedly subtracts the smaller register from the larger, using the datapath comparator flags, until they are equal.
- Holds a done/ack handshake toward the consumer; the result is read from the datapath A register.
- Instantiated alongside the datapath in the GCD top level.

---
 rtl/gcd_pkg.sv | 22 ++
 rtl/gcd_iter_counter.sv | 28 ++
 rtl/gcd_controller.sv | 138 +++++++++++++
 tb/tb_gcd_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller and its helpers.
package gcd_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADB = 2'd1,
        COMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 16;

    // Subtractor operand selects
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Register-input bus selects
    localparam logic BUS_DATA = 1'b0;
    localparam logic BUS_SUB  = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction iteration counter with synchronous clear and terminal count.
// Used only when the controller is built with GCD_CTRL_TIMEOUT_EN.
module gcd_iter_counter #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // Count enabled iterations; clear takes priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == CNT_W'(MAX_ITER));

endmodule

// File: rtl/gcd_controller.sv
// Sequencing FSM for the subtract-and-compare GCD datapath.
// Optional timeout abort is enabled by defining GCD_CTRL_TIMEOUT_EN.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    output logic             lda,
    output logic             ldb,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    input  logic             Lt,
    input  logic             Gt,
    input  logic             Et,
    output logic             done,
    output logic             err,
    input  logic             res_ack
);

    // The counter must be able to represent MAX_ITER
    if ((longint'(1) << CNT_W) <= longint'(MAX_ITER)) begin : g_bad_cnt_w
        $error("gcd_controller: CNT_W too narrow for MAX_ITER");
    end

    state_t state;
    logic   zero_flag;
    logic   accept;
    logic   data_zero;
    logic   tc;

    assign in_ready  = (state == IDLE) || (state == LOADB);
    assign done      = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign data_zero = (data == '0);

`ifdef GCD_CTRL_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;

    // Clear when entering COMP; count every COMP cycle that does not finish
    assign cnt_clr = (state == LOADB) && accept;
    assign cnt_en  = (state == COMP) && !Et && !tc;

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );
`else
    assign tc = 1'b0;
`endif

    // Mealy load enables and datapath selects; Et > timeout > Gt > Lt
    always_comb begin
        lda  = 1'b0;
        ldb  = 1'b0;
        sel1 = SEL_A;
        sel2 = SEL_A;
        sel3 = BUS_DATA;
        case (state)
            IDLE:  lda = accept && rst_n;
            LOADB: ldb = accept;
            COMP: begin
                if (!Et && !tc) begin
                    if (Gt) begin
                        sel1 = SEL_A;
                        sel2 = SEL_B;
                        sel3 = BUS_SUB;
                        lda  = 1'b1;
                    end else if (Lt) begin
                        sel1 = SEL_B;
                        sel2 = SEL_A;
                        sel3 = BUS_SUB;
                        ldb  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State, zero-operand flag and error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err       <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        zero_flag <= data_zero;
                        err       <= 1'b0;
                        state     <= LOADB;
                    end
                end
                LOADB: begin
                    if (accept) begin
                        if (data_zero || zero_flag) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= COMP;
                        end
                    end
                end
                COMP: begin
                    if (Et) begin
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (tc) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller with a behavioural datapath attached.
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int W     = 16;
    localparam int BOUND = 1000;
`ifdef GCD_CTRL_TIMEOUT_EN
    localparam int MAXI = 10;
    localparam bit TMO  = 1'b1;
`else
    localparam int MAXI = 65535;
    localparam bit TMO  = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data = '0;
    logic         lda, ldb, sel1, sel2, sel3;
    logic         Lt, Gt, Et;
    logic         done, err;
    logic         res_ack = 1'b0;

    logic [W-1:0] ra = '0;
    logic [W-1:0] rb = '0;
    logic [W-1:0] op1, op2, bus;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    gcd_controller #(.WIDTH(W), .MAX_ITER(MAXI), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .Lt(Lt), .Gt(Gt), .Et(Et), .done(done), .err(err), .res_ack(res_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: A/B registers, subtractor, bus mux and comparator
    assign op1 = sel1 ? rb : ra;
    assign op2 = sel2 ? rb : ra;
    assign bus = sel3 ? (op1 - op2) : data;
    assign Lt  = ra < rb;
    assign Gt  = ra > rb;
    assign Et  = ra == rb;
    always @(posedge clk) begin
        if (lda) ra <= bus;
        if (ldb) rb <= bus;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: Euclid by repeated subtraction, optionally capped
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int x = a;
        int y = b;
        int n = 0;
        e.err = 1'b0;
        e.res = W'(a);
        e.acc = 0;
        if (a == 0 || b == 0) begin
            e.err = 1'b1;
            e.lat = 0;
            return e;
        end
        while (x != y) begin
            if (TMO && n == MAXI) begin
                e.err = 1'b1;
                break;
            end
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        e.res = W'(x);
        e.lat = n + 1;
        return e;
    endfunction

    // Drive one operand pair; expected result is queued before the B accept edge
    task automatic send(input int a, input int b, input bit push);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        data     = W'(a);
        while (!in_ready) begin
            if (++w > BOUND) begin
                chk("wait_idle_timeout", 32'(w), 32'(BOUND));
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("loadb_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data     = W'(b);
        e = model(a, b);
        e.acc = cyc + 1;
        if (push) sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        data     = W'($urandom);
    endtask

    // Monitor: compare on done rising, then hold and acknowledge
    initial begin
        bit   pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pd = 1'b0;
                continue;
            end
            if (done && !pd) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", 32'(ra), 32'(e.res));
                    chk("err", 32'(err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk("done_hold", 32'(done), 32'd1);
                end
                res_ack = 1'b1;
                @(negedge clk);
                res_ack = 1'b0;
                chk("ack_done_low", 32'(done), 32'd0);
                chk("ack_in_ready", 32'(in_ready), 32'd1);
            end
            pd = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_loads"}, 32'({lda, ldb}), 32'd0);
        chk({tag, "_sels"}, 32'({sel1, sel2, sel3}), 32'd0);
    endtask

    initial begin
        int w;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        send(12, 8, 1);
        send(21, 6, 1);
        send(7, 7, 1);
        send(0, 5, 1);
        send(5, 0, 1);
        send(100, 1, 1);

        // Abort a long run mid-COMP with reset
        send(65535, 1, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        sbq.delete();
        rst_n = 1'b1;
        send(9, 6, 1);

        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 200), $urandom_range(0, 200), 1);
        end

        w = 0;
        while ((sbq.size() != 0 || !in_ready) && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
